// File: rtl/memcpy_seq.sv
// memcpy_seq: multi-cycle sequencer for the MEMCPY instruction.
// While a copy runs it holds the PC, owns the data-memory port and moves
// one word per READ/WRITE pair in ascending address order. When the last
// word is written it gives the port back and pulses done for one cycle.
module memcpy_seq #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 7,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              stall,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [ADDR_W-1:0] buf_r;
    logic              launch_s;

    // A copy starts only for a MEMCPY with a nonzero count; zero is a no-op.
    assign launch_s = start && (count != {CNT_W{1'b0}});

    // State, pointers, word counter and the data buffer between READ and WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            src_ptr_r   <= {ADDR_W{1'b0}};
            dst_ptr_r   <= {ADDR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            buf_r       <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        src_ptr_r   <= src_base;
                        dst_ptr_r   <= dst_base;
                        remaining_r <= count;
                    end
                end
                READ: begin
                    buf_r <= mem_rdata;
                end
                WRITE: begin
                    // Unsigned wrap past the top of the address space is intended.
                    src_ptr_r   <= src_ptr_r + ADDR_W'(WORD_BYTES);
                    dst_ptr_r   <= dst_ptr_r + ADDR_W'(WORD_BYTES);
                    remaining_r <= remaining_r - CNT_W'(1);
                end
                default: begin
                    // DONE: nothing to update, registers hold.
                end
            endcase
        end
    end

    // Next-state selection; start is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = WRITE;
            end
            WRITE: begin
                if (remaining_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = READ;
                end
            end
            DONE: begin
                // Unconditional return so a still-high start cannot retrigger.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode; address and write data stay 0 unless the port is owned.
    always_comb begin
        stall     = 1'b0;
        mem_own   = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wr_en = 1'b0;
        mem_wdata = {ADDR_W{1'b0}};
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            IDLE: begin
                // Combinational so the PC is held in the very first cycle.
                stall = launch_s;
            end
            READ: begin
                stall    = 1'b1;
                mem_own  = 1'b1;
                busy     = 1'b1;
                mem_addr = src_ptr_r;
            end
            WRITE: begin
                stall     = 1'b1;
                mem_own   = 1'b1;
                busy      = 1'b1;
                mem_addr  = dst_ptr_r;
                mem_wdata = buf_r;
                mem_wr_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
